// File: rtl/serial_parity_rx_pkg.sv
// Shared types and helpers for the bit-serial parity frame receiver.
// Holds the FSM state encoding and the parity-check function.
package serial_parity_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // A set result means the data fold plus the received parity bit disagree with the selected sense.
    function automatic logic parity_err(input logic acc, input logic pbit, input logic odd);
        return acc ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/serial_parity_rx_xor.sv
// Two-input XOR gate used as the running parity fold of the receiver.
module serial_parity_rx_xor (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial receiver: start, DATA_WIDTH data bits LSB first, parity, stop.
// Emits each decoded word with registered parity and framing error flags.
module serial_parity_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_parity_err,
    output logic                  out_frame_err
);
    import serial_parity_rx_pkg::*;

    // A single data bit still needs a one-bit counter register.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    rx_state_t             state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  acc_r;
    logic                  perr_r;
    logic                  acc_next_s;

    serial_parity_rx_xor u_fold (
        .a (acc_r),
        .b (in_bit),
        .y (acc_next_s)
    );

    // Frame FSM with registered outputs; everything but the valid pulse advances only on strobed samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= RX_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            shift_r        <= {DATA_WIDTH{1'b0}};
            acc_r          <= 1'b0;
            perr_r         <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= {DATA_WIDTH{1'b0}};
            out_parity_err <= 1'b0;
            out_frame_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                case (state_r)
                    RX_IDLE: begin
                        if (!in_bit) begin
                            state_r <= RX_DATA;
                            cnt_r   <= {CNT_W{1'b0}};
                            acc_r   <= 1'b0;
                        end else begin
                            state_r <= RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        shift_r[cnt_r] <= in_bit;
                        acc_r          <= acc_next_s;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= RX_PARITY;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    RX_PARITY: begin
                        perr_r  <= parity_err(acc_r, in_bit, PARITY_ODD);
                        state_r <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Framing errors still deliver the word; only the flag marks it.
                        out_valid      <= 1'b1;
                        out_data       <= shift_r;
                        out_parity_err <= perr_r;
                        out_frame_err  <= ~in_bit;
                        state_r        <= RX_IDLE;
                    end
                    default: begin
                        state_r <= RX_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
